// File: rtl/bcd_tick_counter.sv
// Prescaled multi-digit BCD event counter with per-digit >9 wrap and same-cycle carry ripple.
// Optional BCD_DOWN_COUNT_EN macro adds a `down` input for decrementing with borrow.

module bcd_digit (
  input  logic [3:0] cur,
  input  logic       cin,
  input  logic       down,
  input  logic [3:0] ld,
  output logic [3:0] nxt,
  output logic       cout,
  output logic       ld_bad
);
  logic [4:0] sum;

  assign sum    = {1'b0, cur} + 5'd1;
  assign ld_bad = (ld > 4'd9);

  always_comb begin
    nxt  = cur;
    cout = 1'b0;
    if (cin) begin
      if (down) begin
        if (cur == 4'd0) begin
          nxt  = 4'd9;
          cout = 1'b1;
        end else begin
          nxt = cur - 4'd1;
        end
      end else if (sum > 5'd9) begin
        nxt  = 4'd0;
        cout = 1'b1;
      end else begin
        nxt = sum[3:0];
      end
    end
  end
endmodule

module bcd_tick_counter #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 100000000,
  parameter int PS_W     = 27
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  load,
`ifdef BCD_DOWN_COUNT_EN
  input  logic                  down,
`endif
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  tick,
  output logic                  carry_out,
  output logic                  ovf,
  output logic                  load_err
);
  logic [PS_W-1:0]            ps;
  logic [DIGITS-1:0][3:0]     cur, nxt, ldv;
  logic [DIGITS-1:0]          bad;
  logic [DIGITS:0]            chain;
  logic                       dn, step, load_ok, wrap;

`ifdef BCD_DOWN_COUNT_EN
  assign dn = down;
`else
  assign dn = 1'b0;
`endif

  assign cur      = bcd;
  assign ldv      = load_val;
  assign chain[0] = 1'b1;
  assign wrap     = chain[DIGITS];
  assign load_ok  = ~|bad;
  assign step     = en && (ps == PS_W'(PRESCALE - 1));

  // carry/borrow ripples through every digit combinationally
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    bcd_digit u_dig (
      .cur    (cur[i]),
      .cin    (chain[i]),
      .down   (dn),
      .ld     (ldv[i]),
      .nxt    (nxt[i]),
      .cout   (chain[i+1]),
      .ld_bad (bad[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ps        <= '0;
      bcd       <= '0;
      ovf       <= 1'b0;
      tick      <= 1'b0;
      carry_out <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      tick      <= 1'b0;
      carry_out <= 1'b0;
      load_err  <= 1'b0;
      if (en) ps <= step ? '0 : ps + 1'b1;
      // a valid load swallows a coincident step; the prescaler still wraps
      if (load && load_ok) begin
        bcd <= load_val;
      end else begin
        load_err <= load;
        if (step) begin
          bcd       <= nxt;
          tick      <= 1'b1;
          carry_out <= wrap;
          if (wrap) ovf <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_bcd_tick_counter.sv
// Scoreboard bench for bcd_tick_counter (DIGITS=2, PRESCALE=4): integer-count model feeds a queue, monitor compares.
module tb_bcd_tick_counter;
  localparam int DIGITS = 2, PRESCALE = 4, PS_W = 2;

  logic clk = 1'b0, rst, en, clr, load, down;
  logic [7:0] load_val, bcd;
  logic tick, carry_out, ovf, load_err;

  typedef struct {
    logic [7:0] bcd;
    logic       tick, carry, ovf, lerr;
  } exp_t;

  exp_t q[$];
  int   total = 0, bad = 0;
  int   m_cnt = 0, m_ps = 0;
  bit   m_ovf = 0;

  always #5 clk = ~clk;

  bcd_tick_counter #(.DIGITS(DIGITS), .PRESCALE(PRESCALE), .PS_W(PS_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .clr       (clr),
    .load      (load),
`ifdef BCD_DOWN_COUNT_EN
    .down      (down),
`endif
    .load_val  (load_val),
    .bcd       (bcd),
    .tick      (tick),
    .carry_out (carry_out),
    .ovf       (ovf),
    .load_err  (load_err)
  );

  // Model: count held as an integer 0..99, BCD produced only for comparison.
  task automatic drive(bit r, bit e, bit c, bit l, logic [7:0] lv, bit dn);
    exp_t x;
    bit stp, lok, wr;
    logic [3:0] hi, lo;
    rst = r; en = e; clr = c; load = l; load_val = lv; down = dn;
    x.tick = 0; x.carry = 0; x.lerr = 0;
    hi = lv[7:4]; lo = lv[3:0];
    if (r || c) begin
      m_cnt = 0; m_ps = 0; m_ovf = 0;
    end else begin
      stp = e && (m_ps == PRESCALE - 1);
      if (e) m_ps = stp ? 0 : m_ps + 1;
      lok = (hi <= 9) && (lo <= 9);
      if (l && lok) begin
        m_cnt = int'(hi) * 10 + int'(lo);
      end else begin
        x.lerr = l;
        if (stp) begin
          x.tick = 1;
`ifdef BCD_DOWN_COUNT_EN
          if (dn) begin
            wr = (m_cnt == 0);
            m_cnt = (m_cnt + 99) % 100;
          end else
`endif
          begin
            wr = (m_cnt == 99);
            m_cnt = (m_cnt + 1) % 100;
          end
          if (wr) begin x.carry = 1; m_ovf = 1; end
        end
      end
    end
    x.bcd = {4'(m_cnt / 10), 4'(m_cnt % 10)};
    x.ovf = m_ovf;
    q.push_back(x);
    @(negedge clk);
  endtask

  task automatic idle(int n, bit e);
    for (int i = 0; i < n; i++) drive(0, e, 0, 0, 8'h00, 0);
  endtask

  // advance until the next enabled edge is a prescaler step
  task automatic to_term();
    for (int i = 0; i < 8 && m_ps != PRESCALE - 1; i++) drive(0, 1, 0, 0, 8'h00, 0);
  endtask

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    exp_t x;
    #1;
    if (q.size() > 0) begin
      x = q.pop_front();
      chk("bcd", bcd, x.bcd);
      chk("tick", {7'd0, tick}, {7'd0, x.tick});
      chk("carry_out", {7'd0, carry_out}, {7'd0, x.carry});
      chk("ovf", {7'd0, ovf}, {7'd0, x.ovf});
      chk("load_err", {7'd0, load_err}, {7'd0, x.lerr});
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] lv;
    rst = 1; en = 0; clr = 0; load = 0; load_val = 0; down = 0;
    // reset with en high
    drive(1, 1, 0, 0, 8'h00, 0);
    drive(1, 1, 0, 0, 8'h00, 0);
    // 40 clocks from 00: ten steps, 09->10 carry
    idle(40, 1);
    // load 99 and run through wrap; ovf sticks across en=0 until clr
    drive(0, 1, 0, 1, 8'h99, 0);
    idle(8, 1);
    idle(5, 0);
    idle(3, 1);
    drive(0, 1, 1, 0, 8'h00, 0);
    // invalid then valid load
    drive(0, 0, 0, 1, 8'h3A, 0);
    drive(0, 0, 0, 1, 8'h42, 0);
    idle(2, 0);
    // clr + load coincident with a step
    drive(0, 1, 0, 1, 8'h99, 0);
    to_term();
    drive(0, 1, 1, 1, 8'h55, 0);
    idle(3, 1);
    // valid load coincident with a step: step dropped
    to_term();
    drive(0, 1, 0, 1, 8'h27, 0);
    idle(4, 1);
    // invalid load coincident with a step: step processed
    to_term();
    drive(0, 1, 0, 1, 8'hF3, 0);
    idle(2, 1);
    // reset mid-count
    drive(1, 1, 0, 1, 8'h11, 0);
`ifdef BCD_DOWN_COUNT_EN
    drive(0, 1, 0, 1, 8'h00, 1);
    to_term();
    drive(0, 1, 0, 0, 8'h00, 1);
    drive(0, 1, 0, 1, 8'h10, 1);
    to_term();
    drive(0, 1, 0, 0, 8'h00, 1);
    idle(2, 1);
`endif
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 1) == 0)
        lv = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      else
        lv = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 40) == 0) lv = 8'h99;
      drive($urandom_range(0, 299) == 0, $urandom_range(0, 7) != 0,
            $urandom_range(0, 149) == 0, $urandom_range(0, 19) == 0, lv,
            $urandom_range(0, 1) == 1);
    end
    idle(2, 0);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
